// File: rtl/uart_controller_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// The producer drives data_in/data_valid; the transmitter answers with data_ready.
interface uart_controller_tx_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/uart_controller_tx.sv
// 8N1/8P1 UART transmitter with a one-entry holding register and zero-gap back-to-back frames.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits (odd when PARITY_ODD=1).
module uart_controller_tx #(
  parameter int CLOCK_RATE = 100_000_000,
  parameter int BAUDE_RATE = 9600,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_controller_tx_if.slave  bus,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int BIT_CYCLES = CLOCK_RATE / BAUDE_RATE;
  localparam int CNT_W      = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [2:0]       STOP_LAST = (STOP_BITS == 2) ? 3'd1 : 3'd0;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitIdx_q, bitIdx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       hold_q, hold_d;
  logic             holdFull_q, holdFull_d;
  logic             tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic bitEnd;
  logic load;
  logic accept;

  assign bitEnd = (cnt_q == CNT_LAST);
  assign accept = bus.data_valid & ~holdFull_q;
  assign tx     = tx_q;

  // State, counters, holding register and the registered line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
      holdFull_q <= 1'b0;
      tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      holdFull_q <= holdFull_d;
      tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // Transitions happen only at a bit boundary, where the counter wraps to 0,
  // so every state is entered with a fresh count.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    holdFull_d = holdFull_q;
    load       = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = bitEnd ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (holdFull_q) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bitEnd) begin
          state_d  = DATA;
          bitIdx_d = '0;
        end
      end
      DATA: begin
        if (bitEnd) begin
          if (bitIdx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
            bitIdx_d = '0;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
            shift_d  = {1'b0, shift_q[7:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bitEnd) begin
          state_d  = STOP;
          bitIdx_d = '0;
        end
      end
`endif
      STOP: begin
        if (bitEnd) begin
          if (bitIdx_q == STOP_LAST) begin
            bitIdx_d = '0;
            if (holdFull_q) begin
              load    = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d    = hold_q;
      holdFull_d = 1'b0;
    end
    if (accept) begin
      hold_d     = bus.data_in;
      holdFull_d = 1'b1;
    end

`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
    if (load) begin
      parity_d = (PARITY_ODD != 0) ? ~^hold_q : ^hold_q;
    end
`endif

    // The line level is computed from the next state so tx leaves a flop.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    bus.data_ready = ~holdFull_q;
    busy           = (state_q != IDLE);
    tx_done        = (state_q == STOP) && bitEnd && (bitIdx_q == STOP_LAST);
  end

endmodule

// File: tb/tb_uart_controller_tx.sv
// Bench for uart_controller_tx: three instances (1 stop/even, 2 stops, 1 stop/odd) checked every
// cycle against a frame-level model, plus hand-computed pins; honours UART_TX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_controller_tx;

  localparam int BC   = 10;
  localparam int NDUT = 3;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam bit PAR_ON  = (PAR_BITS == 1);
  localparam int FRAME_A = (10 + PAR_BITS) * BC;
  localparam int FRAME_B = (11 + PAR_BITS) * BC;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] dataV [NDUT];
  logic [NDUT-1:0] validV;
  wire  [NDUT-1:0] readyV, txV, busyV, doneV;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    uart_controller_tx_if bus ();
    assign bus.data_in    = dataV[g];
    assign bus.data_valid = validV[g];
    assign readyV[g]      = bus.data_ready;

    uart_controller_tx #(
      .CLOCK_RATE(1000),
      .BAUDE_RATE(100),
      .STOP_BITS ((g == 1) ? 2 : 1),
      .PARITY_ODD((g == 2) ? 1 : 0)
    ) dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus),
      .tx     (txV[g]),
      .busy   (busyV[g]),
      .tx_done(doneV[g])
    );
  end

  // Frame-level model: a frame is a list of line levels, one per bit, each held BC cycles.
  int stopN  [NDUT] = '{1, 2, 1};
  bit parOdd [NDUT] = '{1'b0, 1'b0, 1'b1};
  bit        mActive   [NDUT];
  bit        mHoldFull [NDUT];
  bit [7:0]  mHold     [NDUT];
  bit [11:0] mFrame    [NDUT];
  int        mPos      [NDUT];

  function automatic int frameCycles(int g);
    return (9 + PAR_BITS + stopN[g]) * BC;
  endfunction

  function automatic bit [11:0] buildFrame(bit [7:0] b, int g);
    bit [11:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
    if (PAR_ON) f[9] = (^b) ^ parOdd[g];
    return f;
  endfunction

  function automatic bit midFrame(int g);
    return mActive[g] && (mPos[g] < frameCycles(g) - 1);
  endfunction

  function automatic logic expTx(int g);
    return mActive[g] ? mFrame[g][mPos[g] / BC] : 1'b1;
  endfunction

  function automatic logic expDone(int g);
    return mActive[g] && (mPos[g] == frameCycles(g) - 1);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int g = 0; g < NDUT; g++) begin
        mActive[g]   <= 1'b0;
        mHoldFull[g] <= 1'b0;
        mPos[g]      <= 0;
      end
    end else begin
      for (int g = 0; g < NDUT; g++) begin
        if (midFrame(g)) begin
          mPos[g] <= mPos[g] + 1;
        end else if (mHoldFull[g]) begin
          mActive[g] <= 1'b1;
          mPos[g]    <= 0;
          mFrame[g]  <= buildFrame(mHold[g], g);
        end else begin
          mActive[g] <= 1'b0;
          mPos[g]    <= 0;
        end
        if (validV[g] && !mHoldFull[g]) begin
          mHoldFull[g] <= 1'b1;
          mHold[g]     <= dataV[g];
        end else if (mHoldFull[g] && !midFrame(g)) begin
          mHoldFull[g] <= 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(string name, int g, logic act, logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s dut%0d @%0t: actual %b required %b", name, g, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < NDUT; g++) begin
      checkOutput("model_tx",    g, txV[g],    expTx(g));
      checkOutput("model_busy",  g, busyV[g],  mActive[g]);
      checkOutput("model_done",  g, doneV[g],  expDone(g));
      checkOutput("model_ready", g, readyV[g], !mHoldFull[g]);
    end
  end

  task automatic waitCycles(int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the falling edge right after the accepting rising edge.
  task automatic applyStimulus(int g, logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    dataV[g]  = b;
    validV[g] = 1'b1;
    while (!readyV[g] && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_ready", g, readyV[g], 1'b1);
    @(posedge clk);
    @(negedge clk);
    validV[g] = 1'b0;
    dataV[g]  = 8'($urandom_range(0, 255));
  endtask

  typedef struct {
    int         g;
    logic [7:0] b;
    logic       par;
  } parVec_t;

  bit seqA5 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  parVec_t parTab [4] = '{
    '{0, 8'h07, 1'b1},
    '{0, 8'h03, 1'b0},
    '{2, 8'h07, 1'b0},
    '{2, 8'h03, 1'b1}
  };

  initial begin
    validV = '0;
    for (int g = 0; g < NDUT; g++) dataV[g] = 8'h00;
    reset = 1'b1;
    waitCycles(3);
    reset = 1'b0;

    // Idle line after reset
    waitCycles(20);
    checkOutput("idle_tx",    0, txV[0],    1'b1);
    checkOutput("idle_busy",  0, busyV[0],  1'b0);
    checkOutput("idle_ready", 0, readyV[0], 1'b1);
    checkOutput("idle_done",  0, doneV[0],  1'b0);

    // 8'hA5 on an idle line
    applyStimulus(0, 8'hA5);
    checkOutput("a5_ready_held", 0, readyV[0], 1'b0);
    checkOutput("a5_tx_pre",     0, txV[0],    1'b1);
    waitCycles(1);
    checkOutput("a5_start",      0, txV[0],    1'b0);
    checkOutput("a5_busy",       0, busyV[0],  1'b1);
    waitCycles(9);
    checkOutput("a5_start_end",  0, txV[0],    1'b0);
    waitCycles(1);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("a5_bit%0d", i), 0, txV[0], seqA5[i]);
      waitCycles(10);
    end
    checkOutput("a5_bit9", 0, txV[0], PAR_ON ? 1'b0 : 1'b1);
    waitCycles(FRAME_A - 92);
    checkOutput("a5_done_early", 0, doneV[0], 1'b0);
    waitCycles(1);
    checkOutput("a5_done",       0, doneV[0], 1'b1);
    checkOutput("a5_done_busy",  0, busyV[0], 1'b1);
    waitCycles(1);
    checkOutput("a5_done_after", 0, doneV[0], 1'b0);
    checkOutput("a5_idle_busy",  0, busyV[0], 1'b0);
    checkOutput("a5_idle_tx",    0, txV[0],   1'b1);

    // Back-to-back 8'h00 then 8'hFF
    applyStimulus(0, 8'h00);
    applyStimulus(0, 8'hFF);
    waitCycles(FRAME_A - 2);
    checkOutput("b2b_done1",   0, doneV[0],  1'b1);
    checkOutput("b2b_ready1",  0, readyV[0], 1'b0);
    checkOutput("b2b_stop1",   0, txV[0],    1'b1);
    waitCycles(1);
    checkOutput("b2b_start2",  0, txV[0],    1'b0);
    checkOutput("b2b_busy2",   0, busyV[0],  1'b1);
    checkOutput("b2b_ready2",  0, readyV[0], 1'b1);
    waitCycles(FRAME_A + 5);

    // Two stop bits, 8'h3C
    applyStimulus(1, 8'h3C);
    waitCycles(FRAME_B - 19);
    checkOutput("stop2_first", 1, txV[1],   1'b1);
    checkOutput("stop2_busy",  1, busyV[1], 1'b1);
    waitCycles(18);
    checkOutput("stop2_mid",   1, doneV[1], 1'b0);
    checkOutput("stop2_tx",    1, txV[1],   1'b1);
    waitCycles(1);
    checkOutput("stop2_done",  1, doneV[1], 1'b1);
    waitCycles(1);
    checkOutput("stop2_idle",  1, busyV[1], 1'b0);

    // Reset during the fourth data bit of 8'h55
    applyStimulus(0, 8'h55);
    waitCycles(45);
    checkOutput("rst_bit3", 0, txV[0], 1'b0);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_tx",    0, txV[0],    1'b1);
    checkOutput("rst_busy",  0, busyV[0],  1'b0);
    checkOutput("rst_ready", 0, readyV[0], 1'b1);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 8'h96);
    waitCycles(FRAME_A + 5);

    // Parity bit (stop bit when parity is disabled)
    for (int i = 0; i < 4; i++) begin
      applyStimulus(parTab[i].g, parTab[i].b);
      waitCycles(91);
      checkOutput($sformatf("bit9_%02h", parTab[i].b), parTab[i].g,
                  txV[parTab[i].g], PAR_ON ? parTab[i].par : 1'b1);
      waitCycles(25);
    end

    waitCycles(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    miscompares++;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
